// File: rtl/flit_packetizer_if.sv
// Flit packetizer bus interface.
// Groups the descriptor, payload and flit-output handshakes of flit_packetizer.
//   descriptor : pkt_valid_i / pkt_ready_o with pkt_dest_i, pkt_len_i, pkt_vc_i
//   payload    : pld_valid_i / pld_ready_o with pld_data_i
//   flit out   : valid_o / ready_i with fdata_o, vc_id_o
//   status     : busy_o, err_o, pkt_cnt_o
// Modport slave is the packetizer view; master is the driver/sink view.
interface flit_packetizer_if;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [7:0]  pkt_dest_i;
    logic [3:0]  pkt_len_i;
    logic [1:0]  pkt_vc_i;
    logic        pld_valid_i;
    logic        pld_ready_o;
    logic [31:0] pld_data_i;
    logic [33:0] fdata_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  vc_id_o;
    logic        busy_o;
    logic        err_o;
    logic [7:0]  pkt_cnt_o;

    modport slave (
        input  pkt_valid_i, pkt_dest_i, pkt_len_i, pkt_vc_i,
        input  pld_valid_i, pld_data_i, ready_i,
        output pkt_ready_o, pld_ready_o, fdata_o, valid_o,
        output vc_id_o, busy_o, err_o, pkt_cnt_o
    );

    modport master (
        output pkt_valid_i, pkt_dest_i, pkt_len_i, pkt_vc_i,
        output pld_valid_i, pld_data_i, ready_i,
        input  pkt_ready_o, pld_ready_o, fdata_o, valid_o,
        input  vc_id_o, busy_o, err_o, pkt_cnt_o
    );
endinterface

// File: rtl/flit_packetizer.sv
// Flit packetizer.
// Turns a packet descriptor plus len payload words into a head flit followed
// by len-1 body flits and one tail flit, through a single output register
// that sustains one flit per cycle.
//   clk  : rising-edge clock
//   arst : asynchronous active-high reset
//   bus  : flit_packetizer_if.slave (descriptor, payload, flit output, status)
// Flit format: [33:32] type (00 head, 01 body, 11 tail), [31:0] content.
// Head content: vc[31:30], dest[29:22], len[21:18], zeros[17:0].
module flit_packetizer (
    input logic               clk,
    input logic               arst,
    flit_packetizer_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [33:0] fdata_r;
    logic        valid_r;
    logic [1:0]  vc_r;
    logic        err_r;
    logic [7:0]  pkt_cnt_r;

    logic        loadable_s;
    logic        pkt_ready_s;
    logic        pld_ready_s;
    logic        pkt_fire_s;
    logic        pld_fire_s;
    logic        legal_s;
    logic        head_load_s;
    logic        drop_s;
    logic        load_s;
    logic        out_fire_s;
    logic        last_word_s;
    logic [33:0] flit_nxt_s;

    function automatic logic [33:0] head_flit(input logic [1:0] vc,
                                              input logic [7:0] dest,
                                              input logic [3:0] len);
        return {2'b00, vc, dest, len, 18'd0};
    endfunction

    function automatic logic [33:0] payload_flit(input logic        is_tail,
                                                 input logic [31:0] data);
        return {(is_tail ? 2'b11 : 2'b01), data};
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (head_load_s) begin
                    state_nxt_s = PAYLOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PAYLOAD: begin
                if (pld_fire_s && last_word_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PAYLOAD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: handshake readies, load decisions and next-flit mux
    always_comb begin
        // The output register may take a new flit when empty or being drained.
        loadable_s  = !valid_r || bus.ready_i;
        pkt_ready_s = 1'b0;
        pld_ready_s = 1'b0;
        case (state_r)
            IDLE:    pkt_ready_s = loadable_s;
            PAYLOAD: pld_ready_s = loadable_s;
            default: begin
                pkt_ready_s = 1'b0;
                pld_ready_s = 1'b0;
            end
        endcase
        pkt_fire_s  = bus.pkt_valid_i && pkt_ready_s;
        pld_fire_s  = bus.pld_valid_i && pld_ready_s;
        legal_s     = (bus.pkt_dest_i != 8'd0) && (bus.pkt_len_i != 4'd0);
        head_load_s = pkt_fire_s && legal_s;
        // Illegal descriptors are consumed so the source is never stuck on them.
        drop_s      = pkt_fire_s && !legal_s;
        load_s      = head_load_s || pld_fire_s;
        out_fire_s  = valid_r && bus.ready_i;
        last_word_s = (cnt_r == 4'd1);
        if (head_load_s) begin
            flit_nxt_s = head_flit(bus.pkt_vc_i, bus.pkt_dest_i, bus.pkt_len_i);
        end else if (pld_fire_s) begin
            flit_nxt_s = payload_flit(last_word_s, bus.pld_data_i);
        end else begin
            flit_nxt_s = fdata_r;
        end
    end

    // Output register, packet context and status counters
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fdata_r   <= 34'd0;
            valid_r   <= 1'b0;
            vc_r      <= 2'd0;
            cnt_r     <= 4'd0;
            err_r     <= 1'b0;
            pkt_cnt_r <= 8'd0;
        end else begin
            // A load while draining replaces the flit, keeping 1 flit/cycle.
            if (load_s) begin
                fdata_r <= flit_nxt_s;
                valid_r <= 1'b1;
            end else if (out_fire_s) begin
                valid_r <= 1'b0;
            end
            if (head_load_s) begin
                vc_r  <= bus.pkt_vc_i;
                cnt_r <= bus.pkt_len_i;
            end else if (pld_fire_s) begin
                cnt_r <= cnt_r - 4'd1;
            end
            err_r <= drop_s;
            if (out_fire_s && (fdata_r[33:32] == 2'b11)) begin
                pkt_cnt_r <= pkt_cnt_r + 8'd1;
            end
        end
    end

    assign bus.pkt_ready_o = pkt_ready_s;
    assign bus.pld_ready_o = pld_ready_s;
    assign bus.fdata_o     = fdata_r;
    assign bus.valid_o     = valid_r;
    assign bus.vc_id_o     = vc_r;
    assign bus.busy_o      = (state_r == PAYLOAD) || valid_r;
    assign bus.err_o       = err_r;
    assign bus.pkt_cnt_o   = pkt_cnt_r;

endmodule
